// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit load/shift/rotate/clear register with saturating shift counter
// Optional feature macro: PARITY_EN adds the combinational even-parity output "parity".
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cnt_full
`ifdef PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mode_e mode_q;
  logic  is_shift;
  logic [CNT_W-1:0] cnt_next;

  assign mode_q = mode_e'(mode);

  always_comb begin
    is_shift = 1'b0;
    case (mode_q)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: is_shift = 1'b1;
      default:                                is_shift = 1'b0;
    endcase
  end

  // The counter sticks at WIDTH so cnt_full stays asserted until the next load/clear/reset.
  assign cnt_next = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      Q         <= RESET_VALUE;
      shift_cnt <= '0;
    end else if (en) begin
      case (mode_q)
        MODE_LOAD: begin
          Q         <= D;
          shift_cnt <= '0;
        end
        MODE_SHL:   Q <= {Q[WIDTH-2:0], ser_in_r};
        MODE_SHR:   Q <= {ser_in_l, Q[WIDTH-1:1]};
        MODE_ROL:   Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR:   Q <= {Q[0], Q[WIDTH-1:1]};
        MODE_CLEAR: begin
          Q         <= RESET_VALUE;
          shift_cnt <= '0;
        end
        default:    Q <= Q;
      endcase
      if (is_shift) begin
        shift_cnt <= cnt_next;
      end
    end
  end

  assign ser_out_l = Q[WIDTH-1];
  assign ser_out_r = Q[0];
  assign cnt_full  = (shift_cnt == CNT_MAX);

`ifdef PARITY_EN
  assign parity = ^Q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - scoreboard bench for universal_shift_reg (WIDTH=8, RESET_VALUE=0)
// Build with PARITY_EN defined to also cover the parity output.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [WIDTH-1:0] D = '0;
  logic             ser_in_r = 1'b0;
  logic             ser_in_l = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic [CNT_W-1:0] shift_cnt;
  logic             cnt_full;
`ifdef PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  universal_shift_reg #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .D         (D),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .Q         (Q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .shift_cnt (shift_cnt),
    .cnt_full  (cnt_full)
`ifdef PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clocked operation; the expected post-edge state goes to the scoreboard.
  task automatic step(input logic r, input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic sr, input logic sl, input logic [7:0] eq, input logic [3:0] ec);
    @(negedge clk);
    reset    = r;
    en       = e;
    mode     = m;
    D        = d;
    ser_in_r = sr;
    ser_in_l = sl;
    exp_q.push_back('{q: eq, cnt: ec});
  endtask

  // Monitor: every edge the driver issued has one expected entry to pop.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("q", 32'(Q), 32'(ex.q));
        chk("shift_cnt", 32'(shift_cnt), 32'(ex.cnt));
        chk("cnt_full", 32'(cnt_full), 32'(ex.cnt == 4'd8));
        chk("ser_out_l", 32'(ser_out_l), 32'(ex.q[7]));
        chk("ser_out_r", 32'(ser_out_r), 32'(ex.q[0]));
`ifdef PARITY_EN
        chk("parity", 32'(parity), 32'(^ex.q));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    // reset with load requested, then idle with en low
    step(1, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 0);
    step(1, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 0);
    step(0, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0);
    step(0, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0);
    step(0, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0);
    // load then shift left
    step(0, 1, 3'b001, 8'hA5, 0, 0, 8'hA5, 0);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h4B, 1);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'h96, 2);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h2D, 3);
    // rotate right into saturation
    step(0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'hC0, 1);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h60, 2);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h30, 3);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h18, 4);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h0C, 5);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h06, 6);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h03, 7);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h81, 8);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'hC0, 8);
    step(0, 1, 3'b101, 8'h00, 0, 0, 8'h60, 8);
    // rotate left back
    step(0, 1, 3'b100, 8'h00, 0, 0, 8'hC0, 8);
    // shift right with enable gating
    step(0, 1, 3'b001, 8'h0F, 0, 0, 8'h0F, 0);
    step(0, 1, 3'b011, 8'h00, 0, 1, 8'h87, 1);
    step(0, 0, 3'b011, 8'h00, 0, 1, 8'h87, 1);
    step(0, 1, 3'b011, 8'h00, 0, 1, 8'hC3, 2);
    step(0, 0, 3'b011, 8'h00, 0, 1, 8'hC3, 2);
    // reset mid-sequence, reserved mode, clear
    step(0, 1, 3'b001, 8'h3C, 0, 0, 8'h3C, 0);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'h78, 1);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'hF0, 2);
    step(1, 1, 3'b010, 8'h00, 1, 0, 8'h00, 0);
    step(0, 1, 3'b001, 8'h3C, 0, 0, 8'h3C, 0);
    step(0, 1, 3'b111, 8'hFF, 1, 1, 8'h3C, 0);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h79, 1);
    step(0, 1, 3'b110, 8'hFF, 1, 1, 8'h00, 0);
    // WIDTH shift-lefts after a load: Q holds the serial stream, first bit in Q[7]
    step(0, 1, 3'b001, 8'h00, 0, 0, 8'h00, 0);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h01, 1);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'h02, 2);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h05, 3);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h0B, 4);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'h16, 5);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'h2C, 6);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'h59, 7);
    step(0, 1, 3'b010, 8'h00, 0, 0, 8'hB2, 8);
    // alternating shift directions each count
    step(0, 1, 3'b001, 8'h5A, 0, 0, 8'h5A, 0);
    step(0, 1, 3'b010, 8'h00, 1, 0, 8'hB5, 1);
    step(0, 1, 3'b011, 8'h00, 1, 0, 8'h5A, 2);
    step(0, 1, 3'b010, 8'h00, 0, 1, 8'hB4, 3);
    step(0, 1, 3'b011, 8'h00, 0, 1, 8'hDA, 4);
    step(0, 1, 3'b000, 8'hFF, 1, 1, 8'hDA, 4);
    // parity vectors
    step(0, 1, 3'b001, 8'h07, 0, 0, 8'h07, 0);
    step(0, 1, 3'b001, 8'h03, 0, 0, 8'h03, 0);
    @(negedge clk);
    en   = 1'b0;
    mode = 3'b000;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
